// File: rtl/adder_pkg.sv
// Shared constants and helpers for the registered carry-lookahead adder.
package adder_pkg;

    // Default operand/sum width of the adder.
    localparam int ADDER_N = 25;

    // Width of one carry-lookahead slice.
    localparam int CLA_W = 4;

    // Number of lookahead slices needed to cover n bits (last one may be partial).
    function automatic int num_slices(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

endpackage

// File: rtl/adder_reg_cla_slice.sv
// One carry-lookahead slice: bit generate/propagate, expanded internal
// carries, sum bits and the group generate/propagate pair used by the
// second-level lookahead in the top level.
module cla_slice
    import adder_pkg::*;
#(
    parameter int W = CLA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         G,
    output logic         P,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   gen;   // carry into bit i assuming cin = 0
    logic [W:0]   c;     // carry into bit i including cin

    assign g = a & b;
    assign p = a ^ b;

    // Flat sum-of-products carries: c[i+1] = g[i] | p[i]&g[i-1] | ... | p[i..0]&cin.
    always_comb begin
        logic term;
        logic acc;
        logic pall;
        gen    = '0;
        c      = '0;
        c[0]   = cin;
        for (int i = 0; i < W; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            pall = cin;
            for (int m = 0; m <= i; m++) begin
                pall = pall & p[m];
            end
            gen[i+1] = acc;
            c[i+1]   = acc | pall;
        end
    end

    assign s    = p ^ c[W-1:0];
    assign G    = gen[W];
    assign P    = &p;
    assign cout = c[W];

endmodule

// File: rtl/adder_reg.sv
// N-bit unsigned adder with registered {carry_out, sum}. The datapath is a
// row of carry-lookahead slices whose group G/P feed a second-level
// lookahead; the result is captured one clock after the operands are
// presented. There is no handshake: a new addition is accepted every cycle.
module adder_reg
    import adder_pkg::*;
#(
    parameter int N     = ADDER_N,
    parameter int CLA_W = adder_pkg::CLA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    localparam int NS = num_slices(N, CLA_W);

    logic [NS-1:0] grp_g;
    logic [NS-1:0] grp_p;
    logic [NS:0]   grp_c;              // carry into slice k; grp_c[NS] is the final carry
    logic [NS-1:0] slice_cout_unused;  // per-slice ripple carry, superseded by grp_c
    logic [N-1:0]  sum_comb;

    // Slice row; the last slice narrows to whatever bits remain.
    for (genvar k = 0; k < NS; k++) begin : g_slice
        localparam int LO = k * CLA_W;
        localparam int SW = ((N - LO) < CLA_W) ? (N - LO) : CLA_W;

        cla_slice #(
            .W(SW)
        ) u_slice (
            .a    (input1[LO +: SW]),
            .b    (input2[LO +: SW]),
            .cin  (grp_c[k]),
            .s    (sum_comb[LO +: SW]),
            .G    (grp_g[k]),
            .P    (grp_p[k]),
            .cout (slice_cout_unused[k])
        );
    end

    // Second-level lookahead: carry into slice k from group G/P only (no carry-in).
    always_comb begin
        logic term;
        logic acc;
        grp_c    = '0;
        grp_c[0] = 1'b0;
        for (int k = 1; k <= NS; k++) begin
            acc = 1'b0;
            for (int j = 0; j < k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            grp_c[k] = acc;
        end
    end

    // Output register; reset wins over the operand capture on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            sum       <= sum_comb;
            carry_out <= grp_c[NS];
        end
    end

endmodule

// File: tb/tb_adder_reg.sv
// Bench for adder_reg at N=25 and N=7 (partial last slice), both on the
// same clock and reset. Inputs change on the falling edge; outputs are
// compared on the following falling edge against expectations queued when
// the stimulus was applied.
module tb_adder_reg;

    localparam int NA = 25;
    localparam int NB = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NA-1:0] a25 = '0;
    logic [NA-1:0] b25 = '0;
    logic [NB-1:0] a7  = '0;
    logic [NB-1:0] b7  = '0;
    logic [NA-1:0] sum25;
    logic          co25;
    logic [NB-1:0] sum7;
    logic          co7;

    int checks = 0;
    int errors = 0;

    logic [NA:0] exp_q[$];
    logic [NB:0] exp7_q[$];

    typedef struct {
        logic          r;
        logic [NA-1:0] a;
        logic [NA-1:0] b;
        logic [NA:0]   exp;   // {carry_out, sum}
        string         name;
    } vec_t;

    vec_t vecs[10];

    // clock
    always #5 clk = ~clk;

    adder_reg #(.N(NA), .CLA_W(4)) dut25 (
        .clk       (clk),
        .rst       (rst),
        .input1    (a25),
        .input2    (b25),
        .sum       (sum25),
        .carry_out (co25)
    );

    adder_reg #(.N(NB), .CLA_W(4)) dut7 (
        .clk       (clk),
        .rst       (rst),
        .input1    (a7),
        .input2    (b7),
        .sum       (sum7),
        .carry_out (co7)
    );

    // Pop one expectation per DUT and compare against current outputs.
    task automatic check_outputs(input string name);
        logic [NA:0] e25;
        logic [NB:0] e7;
        if (exp_q.size() > 0) begin
            e25 = exp_q.pop_front();
            checks++;
            if ({co25, sum25} !== e25) begin
                errors++;
                $display("FAIL %s n25: got carry=%0b sum=%h, expected carry=%0b sum=%h",
                         name, co25, sum25, e25[NA], e25[NA-1:0]);
            end
        end
        if (exp7_q.size() > 0) begin
            e7 = exp7_q.pop_front();
            checks++;
            if ({co7, sum7} !== e7) begin
                errors++;
                $display("FAIL %s n7: got carry=%0b sum=%h, expected carry=%0b sum=%h",
                         name, co7, sum7, e7[NB], e7[NB-1:0]);
            end
        end
    endtask

    // One clock: check the previous result, then drive new operands and queue
    // what the next edge must produce.
    task automatic cycle(input string name, input logic r, input logic [NA-1:0] a,
                         input logic [NA-1:0] b, input logic [NA:0] exp25,
                         input logic [NB-1:0] x7, input logic [NB-1:0] y7);
        @(negedge clk);
        check_outputs(name);
        rst = r;
        a25 = a;
        b25 = b;
        a7  = x7;
        b7  = y7;
        exp_q.push_back(exp25);
        exp7_q.push_back(r ? '0 : ({1'b0, x7} + {1'b0, y7}));
    endtask

    function automatic logic [NA:0] model25(input logic [NA-1:0] a, input logic [NA-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    initial begin
        logic [NA-1:0] ra, rb;
        logic [NB-1:0] r7a, r7b;

        vecs[0] = '{1'b1, 25'h1FFFFFF, 25'h1FFFFFF, 26'h0000000, "reset_hold0"};
        vecs[1] = '{1'b1, 25'h1FFFFFF, 25'h1FFFFFF, 26'h0000000, "reset_hold1"};
        vecs[2] = '{1'b0, 25'h1FFFFFF, 25'h1FFFFFF, 26'h3FFFFFE, "max_plus_max"};
        vecs[3] = '{1'b0, 25'h1FFF800, 25'h1FFFFFF, 26'h3FFF7FF, "flit_a"};
        vecs[4] = '{1'b0, 25'h03FFFFF, 25'h0000000, 26'h03FFFFF, "flit_b"};
        vecs[5] = '{1'b0, 25'h1FFFFFF, 25'h0000001, 26'h2000000, "max_plus_one"};
        vecs[6] = '{1'b0, 25'h0FFFFFF, 25'h0000001, 26'h1000000, "ripple_to_msb"};
        vecs[7] = '{1'b0, 25'h0000000, 25'h0000000, 26'h0000000, "zero_plus_zero"};
        vecs[8] = '{1'b0, 25'h1555555, 25'h0AAAAAA, 26'h1FFFFFF, "alt_bits"};
        vecs[9] = '{1'b0, 25'h1000000, 25'h1000000, 26'h2000000, "msb_carry"};

        // Table vectors; the N=7 instance sees fixed corner operands alongside.
        for (int i = 0; i < 10; i++) begin
            case (i % 4)
                0:       cycle(vecs[i].name, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, 7'h7F, 7'h7F);
                1:       cycle(vecs[i].name, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, 7'h7F, 7'h01);
                2:       cycle(vecs[i].name, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, 7'h00, 7'h00);
                default: cycle(vecs[i].name, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, 7'h3F, 7'h01);
            endcase
        end

        // Operands change every cycle, then hold for an idle gap.
        for (int i = 0; i < 20; i++) begin
            ra  = NA'($urandom);
            rb  = NA'($urandom);
            r7a = NB'($urandom_range(0, 127));
            r7b = NB'($urandom_range(0, 127));
            cycle("burst", 1'b0, ra, rb, model25(ra, rb), r7a, r7b);
        end
        for (int i = 0; i < 7; i++) begin
            cycle("idle_hold", 1'b0, ra, rb, model25(ra, rb), r7a, r7b);
        end

        // Single-cycle reset in the middle of a burst.
        for (int i = 0; i < 12; i++) begin
            ra  = NA'($urandom);
            rb  = NA'($urandom);
            r7a = NB'($urandom_range(0, 127));
            r7b = NB'($urandom_range(0, 127));
            if (i == 5)
                cycle("midstream_reset", 1'b1, ra, rb, '0, r7a, r7b);
            else
                cycle("post_reset_burst", 1'b0, ra, rb, model25(ra, rb), r7a, r7b);
        end

        // Random operands against the behavioural reference.
        for (int i = 0; i < 10000; i++) begin
            ra  = NA'($urandom);
            rb  = NA'($urandom);
            r7a = NB'($urandom_range(0, 127));
            r7b = NB'($urandom_range(0, 127));
            cycle("random", 1'b0, ra, rb, model25(ra, rb), r7a, r7b);
        end

        // Drain the last queued result.
        @(negedge clk);
        check_outputs("drain");
        if (exp_q.size() != 0 || exp7_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d/%0d entries left, expected 0",
                     exp_q.size(), exp7_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
